pc_reg: RTL and testbench
=========================

Name: pc_reg

Overview:
- Program-counter register for the single-issue RISC-V style core.
- Sits between the next-PC mux (drives `oldpc`) and instruction fetch (consumes `newpc`).
- Captures the next-PC value on each enabled rising clock edge.
- Also provides a sequential-increment output, a load-valid flag and an instruction-address-misaligned flag.

Parameters:
- WIDTH, 32, bit width of all PC buses.
- RESET_VECTOR, 32'h0000_0000, value `newpc` takes during and after reset.
- INCR, 4, byte increment used for `pc_plus`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  load enable; 0 = stall (hold current PC).
- oldpc  input  WIDTH  next-PC value from the next-PC mux.
- newpc  output  WIDTH  current registered PC, to fetch.
- pc_plus  output  WIDTH  newpc + INCR, for the sequential next-PC path.
- valid  output  1  high once at least one PC has been loaded since reset.
- misaligned  output  1  high when newpc[1:0] != 2'b00.

Behaviour:
- Reset, when rst goes 0, asynchronously and immediately, regardless of clk:
  - newpc = RESET_VECTOR
  - valid = 0
  - pc_plus = RESET_VECTOR + INCR
  - misaligned reflects RESET_VECTOR[1:0]
- While rst = 0, all clock edges are ignored and outputs hold reset values.
- Reset release (rst 0 -> 1) is asynchronous in effect. The first rising edge with rst = 1 is a normal edge. No extra recovery cycles.
- Normal operation, rising edge with rst = 1 and en = 1:
  - newpc <= oldpc, verbatim; no masking of the low bits.
  - valid <= 1
  - Latency is 1 cycle: the oldpc value present at the edge appears on newpc immediately after that edge.
- Stall, rising edge with rst = 1 and en = 0: newpc and valid hold their values.
- oldpc changes between edges have no effect on newpc. The input is sampled only at the rising edge.
- pc_plus is combinational: newpc + INCR, truncated to WIDTH bits.
  - Wrap-around is modular: newpc = 32'hFFFF_FFFC gives pc_plus = 32'h0000_0000. No carry-out or flag.
- misaligned is combinational from newpc[1:0].
  - It is informational only. The register still loads the misaligned value, and trap handling is downstream.
- valid stays 1 until the next reset. It never drops on a stall.
- Reset asserted mid-operation (including in the middle of a clock-high phase) overrides en and oldpc immediately.
- Simultaneous rst deassertion and clk rise: reset wins for that edge. The load takes place on the next rising edge.
- No X propagation from an undriven en: en is treated as 0 unless it is 1.
- Implementation is one always_ff block with async negedge rst, plus continuous assigns for the pc_plus and misaligned outputs.

Test Plan:
1. Async reset: rst = 0 with clk idle, oldpc = 32'h0000_1234 -> newpc = 32'h0 immediately, valid = 0, pc_plus = 32'h4, misaligned = 0.
2. Sequential fetch: release rst, en = 1, oldpc = 0, 4, 8 ... 36 on successive edges -> newpc follows one edge later through 32'h24, pc_plus = newpc + 4, valid = 1 after the first edge.
3. Stall: newpc = 32'h10, set en = 0, oldpc = 32'h40 for 3 edges -> newpc holds 32'h10. Raise en -> next edge gives newpc = 32'h40.
4. Wrap-around: load 32'hFFFF_FFFC -> pc_plus = 32'h0000_0000, misaligned = 0.
5. Misaligned load: oldpc = 32'h0000_0102 -> after the edge newpc = 32'h0000_0102, misaligned = 1. Load 32'h104 -> misaligned = 0.
6. Mid-run reset: while loading 32'h80, pull rst low between edges -> newpc = 32'h0 without waiting for clk, valid = 0. Release rst -> the next edge loads the current oldpc.

Source files
------------

// File: rtl/pc_reg_if.sv
// PC register bus: next-PC input from the mux side, current PC and flags out to fetch.
interface pc_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] oldpc;
    logic [WIDTH-1:0] newpc;
    logic [WIDTH-1:0] pc_plus;
    logic             valid;
    logic             misaligned;

    // Next-PC mux / control side
    modport master (
        output en,
        output oldpc,
        input  newpc,
        input  pc_plus,
        input  valid,
        input  misaligned
    );

    // PC register side
    modport slave (
        input  en,
        input  oldpc,
        output newpc,
        output pc_plus,
        output valid,
        output misaligned
    );
endinterface

// File: rtl/pc_reg.sv
// Program-counter register: loads the next PC on enabled edges, holds on stall,
// and provides the sequential increment plus load-valid and misalignment flags.
module pc_reg #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INCR         = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_reg_if.slave  bus
);

    logic [WIDTH-1:0] pc_q;
    logic             valid_q;

    // PC and valid state; an X on en falls through to the hold branch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            pc_q    <= bus.oldpc;
            valid_q <= 1'b1;
        end
    end

    // Sequential next-PC wraps modulo 2^WIDTH with no carry-out
    assign bus.newpc      = pc_q;
    assign bus.pc_plus    = pc_q + WIDTH'(INCR);
    assign bus.valid      = valid_q;
    assign bus.misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed plan items followed by randomized
// load/stall/reset traffic checked against a behavioural PC model.
module tb_pc_reg;

    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int unsigned INCR  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_reg_if #(.WIDTH(WIDTH)) bus ();

    pc_reg #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RV),
        .INCR         (INCR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_pc    = RV;
    logic        m_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_plus;
        logic        exp_mis;
        exp_plus = m_pc + 32'(INCR);
        exp_mis  = (m_pc % 32'd4) != 32'd0;
        check_val({tag, ".newpc"},      bus.newpc,             m_pc);
        check_val({tag, ".pc_plus"},    bus.pc_plus,           exp_plus);
        check_val({tag, ".valid"},      32'(bus.valid),        32'(m_valid));
        check_val({tag, ".misaligned"}, 32'(bus.misaligned),   32'(exp_mis));
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_valid = 1'b0;
    endtask

    // Drive inputs, take one rising edge, update the model, settle past the edge
    task automatic tick(input logic e, input logic [31:0] pc);
        bus.en    = e;
        bus.oldpc = pc;
        @(posedge clk);
        if (rst === 1'b1 && e === 1'b1) begin
            m_pc    = pc;
            m_valid = 1'b1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rpc;
        logic        ren;

        // 1. async reset with no clock edge involved
        bus.en    = 1'b0;
        bus.oldpc = 32'h0000_1234;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");

        // edges during reset are ignored
        tick(1'b1, 32'hDEAD_BEE0);
        tick(1'b1, 32'h0000_1234);
        check_all("held_in_reset");

        // 2. sequential fetch after release
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 32'(i * 4));
            check_all("seq_fetch");
        end
        check_val("seq_final", bus.newpc, 32'h0000_0024);

        // 3. stall then resume
        tick(1'b1, 32'h0000_0010);
        check_all("pre_stall");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0000_0040);
            check_all("stall");
        end
        check_val("stall_hold", bus.newpc, 32'h0000_0010);
        tick(1'b1, 32'h0000_0040);
        check_all("resume");
        check_val("resume_val", bus.newpc, 32'h0000_0040);

        // undriven enable behaves as a stall
        tick(1'bx, 32'h0000_0099);
        check_all("x_enable");

        // 4. wrap-around of the increment
        tick(1'b1, 32'hFFFF_FFFC);
        check_all("wrap");
        check_val("wrap_plus", bus.pc_plus, 32'h0000_0000);

        // 5. misaligned load and recovery
        tick(1'b1, 32'h0000_0102);
        check_all("misaligned");
        check_val("mis_flag", 32'(bus.misaligned), 32'd1);
        tick(1'b1, 32'h0000_0104);
        check_all("aligned");

        // oldpc wiggling between edges has no effect
        #2 bus.oldpc = 32'h0000_0555;
        #1 check_all("between_edges");

        // 6. mid-run reset between edges, then release and load
        tick(1'b1, 32'h0000_0080);
        check_all("pre_midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 32'h0000_0088);
        check_all("post_midrst");

        // randomized traffic with occasional reset during the clock-high phase
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_all("rnd_reset");
                @(negedge clk);
                rst = 1'b1;
            end else begin
                ren = $urandom_range(0, 99) < 70;
                rpc = $urandom;
                if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
                if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFFC;
                tick(ren, rpc);
                check_all("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
